serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: W, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 Port: a  input  W  operand A; captured on accepted start.
REQ-006 Port: b  input  W  operand B; captured on accepted start.
REQ-007 Port: busy  output  1  high while an addition is in progress (ADD state).
REQ-008 Port: done  output  1  one-cycle pulse; sum/cout valid while high and held afterwards.
REQ-009 Port: sum  output  W  result bits [W-1:0] of a+b.
REQ-010 Port: cout  output  1  carry out of bit W-1.

Function
REQ-011 Block shall compute a+b bit-serially, LSB first, one bit per clock, through a single shared full-adder cell.
REQ-012 FSM states shall be IDLE, ADD, DONE.
REQ-013 IDLE: start=1 -> capture a, b into shift registers, clear carry register and bit counter, go to ADD; start=0 -> stay.
REQ-014 ADD: each cycle apply the current LSBs of the A/B shift registers and the carry register to the cell; shift the cell sum into the result register MSB-side; register the cell carry; shift A/B right; increment counter.
REQ-015 ADD shall last exactly W cycles; on the cycle processing bit W-1, go to DONE and load cout from the cell carry.
REQ-016 DONE shall last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-017 Latency: start accepted at edge k -> done high in the cycle after edge k+W; sum/cout valid from that cycle.
REQ-018 start during ADD or DONE shall be ignored (not queued); a, b changes after capture shall not affect the result.
REQ-019 sum and cout shall hold their last result in IDLE until the next accepted start; they may change freely during ADD.
REQ-020 Arithmetic: result modulo 2^W in sum, overflow bit in cout; operands unsigned.
REQ-021 Bit counter width shall be clog2(W)+1; no wrap-around inside one operation.
REQ-022 busy=1 exactly in ADD; busy and done never high together.

Reset
REQ-023 rst=1 at any edge, including mid-ADD or in DONE, shall force IDLE and abort any operation.
REQ-024 Reset values: busy=0, done=0, sum=0, cout=0, carry register=0, counter=0, A/B shift registers=0.
REQ-025 rst shall take priority over start in the same cycle.

Structure
REQ-026 Shared package shall hold the state enumeration (IDLE, ADD, DONE) and the default width constant.
REQ-027 One sub-module, serial_fa_cell: purely combinational full adder made of two half-adder cells plus an OR of their carries; instantiated once.
REQ-028 All registers shall reside in serial_add_ctrl; no latches, no combinational loops through the cell.

Verification (W=8)
REQ-029 a=0x05, b=0x03, start pulse in IDLE -> busy for 8 cycles, done pulse on 9th cycle, sum=0x08, cout=0.
REQ-030 a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0xFF, b=0xFF -> sum=0xFE, cout=1.
REQ-031 start held high and a/b changed to 0x10/0x10 during ADD of 0x05+0x03 -> result 0x08, no second operation; new start accepted only after returning to IDLE.
REQ-032 rst asserted on cycle 4 of ADD -> next cycle busy=0, done=0, sum=0, cout=0, state IDLE; next start computes correctly.
REQ-033 Back-to-back: start held high continuously with 0x7F+0x01 -> done every 10 cycles, each with sum=0x80, cout=0.
REQ-034 Random: 1000 random a/b pairs with random start gaps -> {cout,sum} equals a+b for every done pulse; busy/done never overlap.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_add_ctrl_pkg : shared FSM state encoding and default operand width
// Revision: 1.0
// ---------------------------------------------------------------------------
package serial_add_ctrl_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_add_ctrl_pkg
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_add_ctrl_if : request/result bundle for the bit-serial adder
// Revision: 1.0
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int W = DEFAULT_W
) ();

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );

endinterface : serial_add_ctrl_if
`default_nettype wire

// File: rtl/serial_fa_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_fa_cell : combinational full adder built from two half-adder stages
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_fa_cell (
  input  wire logic a,
  input  wire logic b,
  input  wire logic cin,
  output logic      s,
  output logic      c
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  // first half adder: operand bits; second: partial sum plus incoming carry
  assign ha0_s = a ^ b;
  assign ha0_c = a & b;
  assign s     = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;
  assign c     = ha0_c | ha1_c;

endmodule : serial_fa_cell
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_add_ctrl : LSB-first bit-serial adder, one bit per clock through a
//                   single shared full-adder cell. Revision: 1.0
// ---------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input wire logic         clk,
  input wire logic         rst,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = $clog2(W) + 1;

  state_t        state_q, state_d;
  logic [W-1:0]  a_sr_q, a_sr_d;
  logic [W-1:0]  b_sr_q, b_sr_d;
  logic [W-1:0]  res_q, res_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cout_q, cout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic fa_s;
  logic fa_c;

  serial_fa_cell u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .c   (fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ADD;
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      ST_ADD: begin
        // result fills from the MSB side so bit 0 lands in place after W shifts
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = {fa_s, res_q[W-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = ST_DONE;
          cout_d  = fa_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = res_q;
  assign bus.cout = cout_q;

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl : scoreboard bench; a cycle-count model of the adder
//                      predicts busy/done timing and the a+b results.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst;

  serial_add_ctrl_if #(.W(W)) bus_if ();

  serial_add_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: edges left before the adder is idle again
  int           remain   = 0;
  logic [W:0]   cur_exp  = '0;
  logic [W:0]   exp_hold = '0;
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;
  logic [W:0]   exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted start occupies W ADD cycles plus one DONE cycle.
  always @(posedge clk) begin
    if (rst) begin
      remain   = 0;
      exp_hold = '0;
      exp_q.delete();
    end else if (remain == 0) begin
      if (bus_if.start) begin
        cur_exp = {1'b0, bus_if.a} + {1'b0, bus_if.b};
        exp_q.push_back(cur_exp);
        remain = W + 1;
      end
    end else begin
      remain = remain - 1;
      if (remain == 1) exp_hold = cur_exp;
    end
    exp_busy = (remain > 1);
    exp_done = (remain == 1);
  end

  // Monitor / scoreboard
  always @(posedge clk) begin
    logic [W:0] want;
    #1;
    chk("busy", 64'(bus_if.busy), 64'(exp_busy));
    chk("done", 64'(bus_if.done), 64'(exp_done));
    if (bus_if.busy && bus_if.done) chk("busy_done_overlap", 64'(1), 64'(0));
    if (bus_if.done) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(1), 64'(0));
      end else begin
        want = exp_q.pop_front();
        chk("result", 64'({bus_if.cout, bus_if.sum}), 64'(want));
      end
    end else if (remain == 0) begin
      chk("idle_hold", 64'({bus_if.cout, bus_if.sum}), 64'(exp_hold));
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (remain != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (remain != 0) chk("idle_timeout", 64'(remain), 64'(0));
  endtask

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv);
    wait_idle();
    bus_if.start = 1'b1;
    bus_if.a     = av;
    bus_if.b     = bv;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (W + 2) @(negedge clk);
  endtask

  initial begin
    int dones;
    rst           = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.a      = '0;
    bus_if.b      = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    op(8'h05, 8'h03);
    op(8'hFF, 8'h01);
    op(8'hFF, 8'hFF);
    op(8'h00, 8'h00);

    // start held and operands changed while adding: no effect, no second op
    bus_if.start = 1'b1;
    bus_if.a = 8'h05;
    bus_if.b = 8'h03;
    @(negedge clk);
    bus_if.a = 8'h10;
    bus_if.b = 8'h10;
    repeat (W + 1) @(negedge clk);
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    op(8'h10, 8'h10);

    // reset on cycle 4 of ADD aborts the operation
    bus_if.start = 1'b1;
    bus_if.a = 8'h05;
    bus_if.b = 8'h03;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op(8'h12, 8'h34);

    // reset wins over a simultaneous start
    rst = 1'b1;
    bus_if.start = 1'b1;
    bus_if.a = 8'hAA;
    bus_if.b = 8'h55;
    @(negedge clk);
    rst = 1'b0;
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);

    // back-to-back with start held: one done every W+2 cycles
    bus_if.start = 1'b1;
    bus_if.a = 8'h7F;
    bus_if.b = 8'h01;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.done) dones++;
    end
    bus_if.start = 1'b0;
    chk("b2b_done_count", 64'(dones), 64'(4));
    repeat (W + 3) @(negedge clk);

    // randomized operations with gaps, held starts and scrambled operands
    for (int i = 0; i < 1000; i++) begin
      int gap;
      bit hold;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      wait_idle();
      bus_if.start = 1'b1;
      bus_if.a = W'($urandom);
      bus_if.b = W'($urandom);
      @(negedge clk);
      hold = 1'($urandom_range(0, 1));
      if (!hold) bus_if.start = 1'b0;
      for (int c = 0; c < W + 1; c++) begin
        bus_if.a = W'($urandom);
        bus_if.b = W'($urandom);
        @(negedge clk);
      end
      bus_if.start = 1'b0;
    end

    repeat (2 * W + 4) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_add_ctrl
`default_nettype wire
